// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// datapath select codes, trap causes and the bundled control word.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_LUI       = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WRITE = 4'd7,
    ST_LOAD_WB   = 4'd8,
    ST_ALU_WB    = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JAL       = 4'd11,
    ST_JALR      = 4'd12,
    ST_TRAP      = 4'd13
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_BRANCH = 3'd1;
  localparam logic [2:0] ALU_RTYPE  = 3'd2;
  localparam logic [2:0] ALU_ITYPE  = 3'd3;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
  localparam logic [1:0] SRC_A_ZERO   = 2'd3;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

  localparam logic TRAP_ILLEGAL = 1'b0;
  localparam logic TRAP_TIMEOUT = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_retired;
    logic       trap;
    logic       trap_cause;
  } ctrl_t;

  function automatic state_e decode_dispatch(input logic [6:0] op);
    case (op)
      OP_R:               return ST_EXEC_R;
      OP_I:               return ST_EXEC_I;
      OP_LUI:             return ST_LUI;
      OP_LOAD, OP_STORE:  return ST_MEM_ADDR;
      OP_BRANCH:          return ST_BRANCH;
      OP_JAL:             return ST_JAL;
      OP_JALR:            return ST_JALR;
      default:            return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; o_expired flags that the wait
// limit has been reached. A limit of 0 never expires.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] r_count;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_count && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (MEM_TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// write-back with a memory wait handshake, wait timeout and illegal-opcode trap.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       enable_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_retired_o,
  output logic       trap_o,
  output logic       trap_cause_o,
  output logic [3:0] state_o
);

  state_e r_state;
  state_e w_next_state;
  logic   r_fetch_busy;
  logic   r_trap_cause;
  logic   w_fetch_go;
  logic   w_wait;
  logic   w_clear;
  logic   w_expired;
  ctrl_t  w_ctrl;

  // Once a fetch has been issued it runs to completion even if enable_i drops.
  assign w_fetch_go = enable_i || r_fetch_busy;
  assign w_wait     = !mem_ready_i &&
                      (((r_state == ST_FETCH) && w_fetch_go) ||
                       (r_state == ST_MEM_READ) || (r_state == ST_MEM_WRITE));
  assign w_clear    = (w_next_state != r_state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_count   (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_busy <= 1'b0;
      r_trap_cause <= TRAP_ILLEGAL;
    end else begin
      r_fetch_busy <= (r_state == ST_FETCH) && w_fetch_go && !mem_ready_i && !w_expired;
      if ((w_next_state == ST_TRAP) && (r_state != ST_TRAP))
        r_trap_cause <= (r_state == ST_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
    end
  end

  // NOTE: default assignment first so every path of the comb block drives the signal (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:     if (w_expired) w_next_state = ST_TRAP;
                    else if (w_fetch_go && mem_ready_i) w_next_state = ST_DECODE;
      ST_DECODE:    w_next_state = decode_dispatch(opcode_i);
      ST_EXEC_R,
      ST_EXEC_I,
      ST_LUI:       w_next_state = ST_ALU_WB;
      ST_MEM_ADDR:  w_next_state = (opcode_i == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (w_expired) w_next_state = ST_TRAP;
                    else if (mem_ready_i) w_next_state = ST_LOAD_WB;
      ST_MEM_WRITE: if (w_expired) w_next_state = ST_TRAP;
                    else if (mem_ready_i) w_next_state = ST_FETCH;
      ST_TRAP:      w_next_state = ST_TRAP;
      default:      w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          w_ctrl.alu_src_a = SRC_A_PC;
          w_ctrl.alu_src_b = SRC_B_FOUR;
          w_ctrl.alu_op    = ALU_ADD;
          w_ctrl.pc_source = PCSRC_ALU;
          w_ctrl.mem_read  = w_fetch_go;
          w_ctrl.ir_write  = w_fetch_go && mem_ready_i && !w_expired;
          w_ctrl.pc_write  = w_fetch_go && mem_ready_i && !w_expired;
        end
        ST_DECODE: begin
          w_ctrl.alu_src_a = SRC_A_OLD_PC;
          w_ctrl.alu_src_b = SRC_B_IMM;
        end
        ST_EXEC_R: begin
          w_ctrl.alu_src_a = SRC_A_RS1;
          w_ctrl.alu_src_b = SRC_B_RS2;
          w_ctrl.alu_op    = ALU_RTYPE;
        end
        ST_EXEC_I: begin
          w_ctrl.alu_src_a = SRC_A_RS1;
          w_ctrl.alu_src_b = SRC_B_IMM;
          w_ctrl.alu_op    = ALU_ITYPE;
        end
        ST_LUI: begin
          w_ctrl.alu_src_a = SRC_A_ZERO;
          w_ctrl.alu_src_b = SRC_B_IMM;
        end
        ST_ALU_WB: begin
          w_ctrl.reg_write     = 1'b1;
          w_ctrl.mem_to_reg    = WB_ALUOUT;
          w_ctrl.instr_retired = 1'b1;
        end
        ST_MEM_ADDR: begin
          w_ctrl.alu_src_a = SRC_A_RS1;
          w_ctrl.alu_src_b = SRC_B_IMM;
        end
        ST_MEM_READ: begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.i_or_d   = 1'b1;
        end
        ST_LOAD_WB: begin
          w_ctrl.reg_write     = 1'b1;
          w_ctrl.mem_to_reg    = WB_MDR;
          w_ctrl.instr_retired = 1'b1;
        end
        ST_MEM_WRITE: begin
          // The strobe is withheld on the timeout cycle so no store lands.
          w_ctrl.mem_write     = !w_expired;
          w_ctrl.i_or_d        = 1'b1;
          w_ctrl.instr_retired = mem_ready_i && !w_expired;
        end
        ST_BRANCH: begin
          w_ctrl.alu_src_a     = SRC_A_RS1;
          w_ctrl.alu_src_b     = SRC_B_RS2;
          w_ctrl.alu_op        = ALU_BRANCH;
          w_ctrl.pc_write_cond = 1'b1;
          w_ctrl.pc_source     = PCSRC_ALUOUT;
          w_ctrl.instr_retired = 1'b1;
        end
        ST_JAL: begin
          w_ctrl.reg_write     = 1'b1;
          w_ctrl.mem_to_reg    = WB_PC;
          w_ctrl.pc_write      = 1'b1;
          w_ctrl.pc_source     = PCSRC_ALUOUT;
          w_ctrl.instr_retired = 1'b1;
        end
        ST_JALR: begin
          w_ctrl.alu_src_a     = SRC_A_RS1;
          w_ctrl.alu_src_b     = SRC_B_IMM;
          w_ctrl.pc_write      = 1'b1;
          w_ctrl.pc_source     = PCSRC_JALR;
          w_ctrl.reg_write     = 1'b1;
          w_ctrl.mem_to_reg    = WB_PC;
          w_ctrl.instr_retired = 1'b1;
        end
        ST_TRAP: begin
          w_ctrl.trap       = 1'b1;
          w_ctrl.trap_cause = r_trap_cause;
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  assign pc_write_o      = w_ctrl.pc_write;
  assign pc_write_cond_o = w_ctrl.pc_write_cond;
  assign ir_write_o      = w_ctrl.ir_write;
  assign mem_read_o      = w_ctrl.mem_read;
  assign mem_write_o     = w_ctrl.mem_write;
  assign i_or_d_o        = w_ctrl.i_or_d;
  assign reg_write_o     = w_ctrl.reg_write;
  assign mem_to_reg_o    = w_ctrl.mem_to_reg;
  assign alu_src_a_o     = w_ctrl.alu_src_a;
  assign alu_src_b_o     = w_ctrl.alu_src_b;
  assign alu_op_o        = w_ctrl.alu_op;
  assign pc_source_o     = w_ctrl.pc_source;
  assign instr_retired_o = w_ctrl.instr_retired;
  assign trap_o          = w_ctrl.trap;
  assign trap_cause_o    = w_ctrl.trap_cause;
  assign state_o         = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed and randomized instruction streams against an instruction-level
// model of the control FSM (state walk per opcode, wait counts, latency table).
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  localparam int unsigned TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       enable_i;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o;
  logic       i_or_d_o, reg_write_o, instr_retired_o, trap_o, trap_cause_o;
  logic [1:0] mem_to_reg_o, alu_src_a_o, alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt;
  int ret_at;

  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_i        (opcode_i),
    .mem_ready_i     (mem_ready_i),
    .enable_i        (enable_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .ir_write_o      (ir_write_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .i_or_d_o        (i_or_d_o),
    .reg_write_o     (reg_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_source_o     (pc_source_o),
    .instr_retired_o (instr_retired_o),
    .trap_o          (trap_o),
    .trap_cause_o    (trap_cause_o),
    .state_o         (state_o)
  );

  logic [20:0] obs_ctrl;
  assign obs_ctrl = {pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o,
                     i_or_d_o, reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                     alu_op_o, pc_source_o, instr_retired_o, trap_o, trap_cause_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Control word each state presents, straight from the state/output table.
  function automatic logic [20:0] exp_ctrl(input state_e st, input logic rdy, input logic go,
                                           input logic expiring, input logic cause);
    logic pcw, pcwc, irw, mr, mw, iod, rw, ret, trp, tc;
    logic [1:0] m2r, sa, sb, ps;
    logic [2:0] op;
    {pcw, pcwc, irw, mr, mw, iod, rw, ret, trp, tc} = '0;
    {m2r, sa, sb, ps} = '0;
    op = '0;
    case (st)
      ST_FETCH:     begin sb = 2'd1; mr = go; irw = go & rdy & ~expiring; pcw = irw; end
      ST_DECODE:    begin sa = 2'd2; sb = 2'd2; end
      ST_EXEC_R:    begin sa = 2'd1; sb = 2'd0; op = 3'd2; end
      ST_EXEC_I:    begin sa = 2'd1; sb = 2'd2; op = 3'd3; end
      ST_LUI:       begin sa = 2'd3; sb = 2'd2; end
      ST_ALU_WB:    begin rw = 1'b1; ret = 1'b1; end
      ST_MEM_ADDR:  begin sa = 2'd1; sb = 2'd2; end
      ST_MEM_READ:  begin mr = 1'b1; iod = 1'b1; end
      ST_LOAD_WB:   begin rw = 1'b1; m2r = 2'd1; ret = 1'b1; end
      ST_MEM_WRITE: begin mw = ~expiring; iod = 1'b1; ret = rdy & ~expiring; end
      ST_BRANCH:    begin sa = 2'd1; op = 3'd1; pcwc = 1'b1; ps = 2'd1; ret = 1'b1; end
      ST_JAL:       begin rw = 1'b1; m2r = 2'd2; pcw = 1'b1; ps = 2'd1; ret = 1'b1; end
      ST_JALR:      begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; ps = 2'd2; rw = 1'b1;
                          m2r = 2'd2; ret = 1'b1; end
      ST_TRAP:      begin trp = 1'b1; tc = cause; end
      default:      ;
    endcase
    return {pcw, pcwc, irw, mr, mw, iod, rw, m2r, sa, sb, op, ps, ret, trp, tc};
  endfunction

  task automatic step(input state_e st, input logic rdy, input logic go,
                      input logic expiring, input logic cause, input string tag);
    @(negedge clk);
    mem_ready_i = rdy;
    #1;
    cyc_cnt++;
    check({tag, " ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl(st, rdy, go, expiring, cause)));
    check({tag, " state"}, 32'(state_o), 32'(st));
    if (instr_retired_o === 1'b1 && ret_at < 0) ret_at = cyc_cnt;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    mem_ready_i = 1'($urandom);
    #1;
    check({tag, " ctrl"}, 32'(obs_ctrl), 32'd0);
    check({tag, " state"}, 32'(state_o), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    enable_i = 1'b1;
  endtask

  // Walks one instruction through its state list; fw/mw are wait cycles
  // inserted in FETCH and in the data memory state.
  task automatic run_instr(input logic [6:0] op, input string tag, input int fw, input int mw);
    state_e seq[$];
    int lat;
    int waits = 0;
    cyc_cnt = 0;
    ret_at  = -1;
    case (op)
      7'b0110011: begin seq = {ST_FETCH, ST_DECODE, ST_EXEC_R, ST_ALU_WB}; lat = 4; end
      7'b0010011: begin seq = {ST_FETCH, ST_DECODE, ST_EXEC_I, ST_ALU_WB}; lat = 4; end
      7'b0110111: begin seq = {ST_FETCH, ST_DECODE, ST_LUI, ST_ALU_WB}; lat = 4; end
      7'b0000011: begin seq = {ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_LOAD_WB}; lat = 5; end
      7'b0100011: begin seq = {ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WRITE}; lat = 4; end
      7'b1100011: begin seq = {ST_FETCH, ST_DECODE, ST_BRANCH}; lat = 3; end
      7'b1101111: begin seq = {ST_FETCH, ST_DECODE, ST_JAL}; lat = 3; end
      default:    begin seq = {ST_FETCH, ST_DECODE, ST_JALR}; lat = 3; end
    endcase
    enable_i = 1'b1;
    opcode_i = 7'($urandom);
    foreach (seq[k]) begin
      bit is_mem;
      int w;
      is_mem = (seq[k] == ST_FETCH) || (seq[k] == ST_MEM_READ) || (seq[k] == ST_MEM_WRITE);
      w = (seq[k] == ST_FETCH) ? fw : (is_mem ? mw : 0);
      if (k == 1) opcode_i = op;
      if (k == 2) enable_i = 1'($urandom);
      for (int i = 0; i < w; i++) step(seq[k], 1'b0, 1'b1, 1'b0, 1'b0, tag);
      waits += w;
      step(seq[k], is_mem ? 1'b1 : 1'($urandom), 1'b1, 1'b0, 1'b0, tag);
    end
    enable_i = 1'b1;
    check({tag, " latency"}, 32'(ret_at), 32'(lat + waits));
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] bad_op;
    reset = 1'b1; enable_i = 1'b1; mem_ready_i = 1'b0; opcode_i = '0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Directed instruction-level cases.
    run_instr(7'b0110011, "add",  0, 0);
    run_instr(7'b0000011, "lw",   0, 2);
    run_instr(7'b1100011, "beq",  0, 0);
    run_instr(7'b1101111, "jal",  0, 0);
    run_instr(7'b1100111, "jalr", 0, 0);
    run_instr(7'b0100011, "sw",   1, 3);
    run_instr(7'b0010011, "addi", 2, 0);
    run_instr(7'b0110111, "lui",  0, 0);

    // Fetch held off by enable_i.
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) step(ST_FETCH, 1'($urandom), 1'b0, 1'b0, 1'b0, "idle");
    run_instr(7'b0110011, "add_after_idle", 0, 0);

    // Randomized legal stream; waits stay below the timeout.
    for (int n = 0; n < 40; n++)
      run_instr(legal_ops[$urandom_range(0, 7)], "rand",
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Illegal opcode 0000000 traps and stays trapped.
    step(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, "ill_fetch");
    opcode_i = 7'b0000000;
    step(ST_DECODE, 1'($urandom), 1'b1, 1'b0, 1'b0, "ill_decode");
    for (int i = 0; i < 100; i++) begin
      enable_i = 1'($urandom);
      step(ST_TRAP, 1'($urandom), 1'b1, 1'b0, 1'b0, "ill_trap");
    end
    do_reset("ill_reset");

    // Random illegal opcodes.
    for (int n = 0; n < 4; n++) begin
      do bad_op = 7'($urandom); while (is_legal(bad_op));
      step(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, "rill_fetch");
      opcode_i = bad_op;
      step(ST_DECODE, 1'b1, 1'b1, 1'b0, 1'b0, "rill_decode");
      for (int i = 0; i < 3; i++) step(ST_TRAP, 1'($urandom), 1'b1, 1'b0, 1'b0, "rill_trap");
      do_reset("rill_reset");
    end

    // Store with memory never ready: trap on the 5th wait edge, no write issued.
    step(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, "sw_to_fetch");
    opcode_i = 7'b0100011;
    step(ST_DECODE, 1'b0, 1'b1, 1'b0, 1'b0, "sw_to_decode");
    step(ST_MEM_ADDR, 1'b0, 1'b1, 1'b0, 1'b0, "sw_to_addr");
    for (int i = 0; i < int'(TIMEOUT); i++) step(ST_MEM_WRITE, 1'b0, 1'b1, 1'b0, 1'b0, "sw_to_wait");
    step(ST_MEM_WRITE, 1'b0, 1'b1, 1'b1, 1'b0, "sw_to_expire");
    for (int i = 0; i < 5; i++) step(ST_TRAP, 1'($urandom), 1'b1, 1'b0, 1'b1, "sw_to_trap");
    do_reset("sw_to_reset");

    // Fetch timeout.
    for (int i = 0; i < int'(TIMEOUT); i++) step(ST_FETCH, 1'b0, 1'b1, 1'b0, 1'b0, "if_to_wait");
    step(ST_FETCH, 1'b0, 1'b1, 1'b1, 1'b0, "if_to_expire");
    for (int i = 0; i < 3; i++) step(ST_TRAP, 1'($urandom), 1'b1, 1'b0, 1'b1, "if_to_trap");
    do_reset("if_to_reset");

    // Reset asserted while a store waits in MEM_WRITE.
    step(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, "swr_fetch");
    opcode_i = 7'b0100011;
    step(ST_DECODE, 1'b1, 1'b1, 1'b0, 1'b0, "swr_decode");
    step(ST_MEM_ADDR, 1'b1, 1'b1, 1'b0, 1'b0, "swr_addr");
    step(ST_MEM_WRITE, 1'b0, 1'b1, 1'b0, 1'b0, "swr_write");
    do_reset("swr_reset");
    run_instr(7'b0110011, "add_after_reset", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multi-cycle RV32I core variant. It sequences the shared datapath through one instruction at a time: fetch, decode, execute, memory and write-back. All datapath mux selects and write enables are driven from here. It replaces the single-cycle opcode decoder, and it adds three things that decoder lacks: a memory wait-state handshake, a wait timeout, and an illegal-opcode trap.

## Interface
- MEM_TIMEOUT, default 16: maximum cycles to wait for mem_ready_i in any memory state before trapping. 0 disables the timeout.
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high.
- opcode_i  input  7  instruction_register[6:0]; valid from DECODE onward.
- mem_ready_i  input  1  memory completes the current read or write at this edge.
- enable_i  input  1  allows a new fetch to start; sampled in FETCH only.
- pc_write_o, pc_write_cond_o, ir_write_o  output  1 each  PC write, conditional PC write (datapath ANDs it with branch_taken), IR/old-PC write.
- mem_read_o, mem_write_o, i_or_d_o  output  1 each  memory strobes; address select (0 = PC, 1 = ALUOut).
- reg_write_o  output  1  register file write enable.
- mem_to_reg_o  output  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC.
- alu_src_a_o  output  2  ALU A select: 0 = PC, 1 = rs1, 2 = old PC, 3 = zero.
- alu_src_b_o  output  2  ALU B select: 0 = rs2, 1 = constant 4, 2 = immediate.
- alu_op_o  output  3  ALU op class for ALU_Control: 0 = ADD, 1 = BRANCH, 2 = R-type, 3 = I-type.
- pc_source_o  output  2  next-PC source: 0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1.
- instr_retired_o  output  1  one-cycle pulse on an instruction's final cycle.
- trap_o, trap_cause_o  output  1 each  halted; cause: 0 = illegal opcode, 1 = memory timeout.
- state_o  output  4  current state encoding, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, LUI, MEM_ADDR, MEM_READ, MEM_WRITE, LOAD_WB, ALU_WB, BRANCH, JAL, JALR, TRAP.
- All outputs are Moore outputs (decoded from the state only), except the mem_ready_i-qualified enables noted below. Any signal not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, A=PC, B=4, ADD, pc_source=0.
  - ir_write and pc_write = mem_ready_i.
  - Go to DECODE when mem_ready_i=1.
  - If enable_i=0 on entry, no strobes are asserted and the FSM stays in FETCH.
- DECODE: A=old PC, B=imm, ADD, so ALUOut captures the branch/JAL target. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111 → LUI
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - anything else → TRAP, cause 0
- EXEC_R: A=rs1, B=rs2, R-type → ALU_WB.
- EXEC_I: A=rs1, B=imm, I-type → ALU_WB.
- LUI: A=zero, B=imm, ADD → ALU_WB.
- ALU_WB: reg_write, mem_to_reg=0, retire → FETCH.
- MEM_ADDR: A=rs1, B=imm, ADD → MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_read, i_or_d=1 → LOAD_WB when mem_ready_i=1.
- LOAD_WB: reg_write, mem_to_reg=1, retire → FETCH.
- MEM_WRITE: mem_write, i_or_d=1; retire → FETCH when mem_ready_i=1.
- BRANCH: A=rs1, B=rs2, BRANCH op, pc_write_cond, pc_source=1, retire → FETCH.
- JAL: reg_write, mem_to_reg=2 (PC already holds PC+4), pc_write, pc_source=1, retire → FETCH.
- JALR: A=rs1, B=imm, ADD, pc_write, pc_source=2, reg_write, mem_to_reg=2, retire → FETCH.
- TRAP: all strobes 0, trap_o=1, trap_cause_o held. Left only via reset.
- Wait counter:
  - Counts consecutive cycles with mem_ready_i=0 in FETCH (with enable_i=1), MEM_READ or MEM_WRITE.
  - Clears on any state change.
  - When the count reaches MEM_TIMEOUT, the next state is TRAP with cause 1, and no write strobe is issued that cycle.

## Timing
- Reset:
  - While reset=1, all outputs are forced to 0, the state is forced to FETCH and the counter is cleared.
  - In the first cycle after reset deasserts, the FSM is in FETCH.
  - trap_o=0 and instr_retired_o=0 on reset.
- Latency with mem_ready_i held at 1:
  - R/I/LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/JAL/JALR: 3 cycles.
  - Each cycle with mem_ready_i=0 in a memory state adds 1 cycle.
- Memory handshake: mem_read_o/mem_write_o and i_or_d_o are held stable until the edge where mem_ready_i=1. The transfer completes at that edge.
- enable_i only gates the start of a fetch. Dropping it mid-instruction has no effect until the next FETCH.
- A reset asserted mid-instruction aborts it at the next edge; partial writes already committed are not undone.

## Structure
- Package riscv_ctrl_pkg holds:
  - state encoding, with FETCH = 0
  - opcode constants
  - alu_op, alu_src_a/b, mem_to_reg and pc_source select constants
  - trap cause codes
- Sub-module mem_wait_timer: counter of width $clog2(MEM_TIMEOUT+1), with clear and count inputs and an expired output.

## Test plan
- ADD (0110011), mem_ready_i=1 → states FETCH, DECODE, EXEC_R, ALU_WB. reg_write=1 and instr_retired=1 only in cycle 4; alu_op=2 in EXEC_R.
- LW with mem_ready_i=0 for 2 cycles in MEM_READ → retires on cycle 7. mem_read and i_or_d stay 1 through the wait; reg_write with mem_to_reg=1 in LOAD_WB.
- BEQ, JAL, JALR each 3 cycles:
  - BEQ: pc_write_cond=1, pc_source=1.
  - JAL: pc_write, reg_write and mem_to_reg=2 in the same cycle.
  - JALR: pc_source=2.
- Opcode 0000000 → TRAP after DECODE with trap_o=1, trap_cause_o=0; FSM stays there for 100 cycles; reset returns it to FETCH.
- MEM_TIMEOUT=4, SW with mem_ready_i stuck at 0 → TRAP with cause 1 on the 5th wait edge; mem_write is never completed.
- enable_i=0 at FETCH for 3 cycles → no mem_read. Reset asserted in MEM_WRITE → all outputs 0, then FETCH.
